clock_segment_recorder: RTL and testbench

- Capture-side counterpart of the segmented clock generator.
- Samples an external clock on refclk and measures the high-time and low-time of every period in refclk cycles.
- Run-length compresses identical consecutive periods into 128-bit segment words in the generator's own FIFO format, so a recorded word list replays through the generator and reproduces the input waveform.
- Feeds a downstream 128-bit FIFO / pipe-out serializer through a valid/ready handshake; it is controlled and polled through ok trigger/wire endpoints.

---
 rtl/clock_segment_recorder.sv | 172 +++++++++++++++++
 tb/tb_clock_segment_recorder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_segment_recorder.sv
// Records an external clock as run-length compressed {high, low, repeat} segment
// words, in the same 128-bit format the segmented clock generator replays.
module clock_segment_recorder #(
  parameter int CNT_W = 48,
  parameter int REP_W = 32
) (
  input  logic                     refclk,
  input  logic                     reset,
  input  logic                     sig_in,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         timeout_counts,
  input  logic                     seg_ready,
  output logic                     seg_valid,
  output logic [2*CNT_W+REP_W-1:0] seg_data,
  output logic                     recording,
  output logic [15:0]              status,
  output logic [31:0]              n_segments
);

  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic [REP_W-1:0] rep;
  } seg_t;

  typedef enum logic [2:0] {IDLE, ARMED, HIGH, LOW, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [REP_W-1:0] REP_MAX = '1;

  state_t           state, state_nxt;
  logic [2:0]       sync_pipe;
  logic             sync, prev, rise, free;
  logic [CNT_W-1:0] hcnt, lcnt, h_lat, close_l;
  logic             hi_to, lo_to;
  seg_t             cur, cur_nxt, new_seg, emit_word, seg_q;
  logic             cur_v, cur_v_nxt;
  logic             start, aborted, stuck, finish, close, flush_emit, emit_req;
  logic [3:0]       st;

  // [0] metastability flop, [1] synchronised level, [2] previous level
  assign sync = sync_pipe[1];
  assign prev = sync_pipe[2];
  assign rise = sync & ~prev;
  assign free = ~seg_valid | seg_ready;
  assign hi_to = (timeout_counts != '0) && (hcnt == timeout_counts);
  assign lo_to = (timeout_counts != '0) && (lcnt == timeout_counts);

  assign seg_data   = seg_q;
  assign status     = {12'b0, st};

  always_ff @(posedge refclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    aborted    = 1'b0;
    stuck      = 1'b0;
    finish     = 1'b0;
    close      = 1'b0;
    close_l    = lcnt;
    flush_emit = 1'b0;
    if (state != IDLE && abort) begin
      aborted   = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (arm && !abort) begin start = 1'b1; state_nxt = ARMED; end
        ARMED: if (rise) state_nxt = HIGH;
        HIGH: begin
          if (!sync) state_nxt = LOW;
          else if (hi_to) begin stuck = 1'b1; state_nxt = FLUSH; end
        end
        LOW: begin
          if (rise) begin
            close     = 1'b1;
            state_nxt = HIGH;
          end else if (lo_to) begin
            close     = 1'b1;
            close_l   = timeout_counts;
            finish    = 1'b1;
            state_nxt = FLUSH;
          end
        end
        FLUSH: begin
          if (!cur_v) state_nxt = IDLE;
          else if (free) begin flush_emit = 1'b1; state_nxt = IDLE; end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // merge the closed pair into the current run, or retire the run
    new_seg   = {h_lat, close_l, REP_W'(1)};
    cur_nxt   = cur;
    cur_v_nxt = cur_v;
    emit_req  = 1'b0;
    emit_word = cur;
    if (start || aborted) begin
      cur_v_nxt = 1'b0;
    end else if (close) begin
      if (!cur_v) begin
        cur_nxt   = new_seg;
        cur_v_nxt = 1'b1;
      end else if (cur.h == new_seg.h && cur.l == new_seg.l && cur.rep != REP_MAX) begin
        cur_nxt.rep = cur.rep + 1'b1;
      end else begin
        emit_req = 1'b1;
        cur_nxt  = new_seg;
      end
    end else if (flush_emit) begin
      emit_req  = 1'b1;
      cur_v_nxt = 1'b0;
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      sync_pipe  <= '0;
      hcnt       <= '0;
      lcnt       <= '0;
      h_lat      <= '0;
      cur        <= '0;
      cur_v      <= 1'b0;
      seg_q      <= '0;
      seg_valid  <= 1'b0;
      recording  <= 1'b0;
      st         <= '0;
      n_segments <= '0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], sig_in};
      cur       <= cur_nxt;
      cur_v     <= cur_v_nxt;

      if ((state == ARMED || state == LOW) && rise) hcnt <= CNT_W'(1);
      else if (state == HIGH && sync && hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;

      if (state == HIGH && !sync) begin
        h_lat <= hcnt;
        lcnt  <= CNT_W'(1);
      end else if (state == LOW && !sync && lcnt != CNT_MAX) begin
        lcnt <= lcnt + 1'b1;
      end

      // a full register with no ready loses the new word, not the held one
      if (emit_req && free) begin
        seg_q     <= emit_word;
        seg_valid <= 1'b1;
      end else if (seg_ready) begin
        seg_valid <= 1'b0;
      end

      if (start) begin
        st         <= '0;
        n_segments <= '0;
        recording  <= 1'b1;
      end else begin
        if (state != IDLE && state_nxt == IDLE) recording <= 1'b0;
        if (aborted) st[1] <= 1'b1;
        if (stuck)   st[2] <= 1'b1;
        if (finish)  st[0] <= 1'b1;
        if (emit_req && !free) st[3] <= 1'b1;
        if (emit_req && free)  n_segments <= n_segments + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_clock_segment_recorder.sv
// Directed bench: expected segment words are queued as stimulus is driven and
// popped by a monitor whenever a word is handed over downstream.
module tb_clock_segment_recorder;

  logic          refclk;
  logic          reset;
  logic          sig_in;
  logic          arm;
  logic          abort;
  logic [47:0]   timeout_counts;
  logic          seg_ready;
  logic          seg_valid;
  logic [127:0]  seg_data;
  logic          recording;
  logic [15:0]   status;
  logic [31:0]   n_segments;

  int n_assert = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];

  clock_segment_recorder dut (
    .refclk(refclk), .reset(reset), .sig_in(sig_in), .arm(arm), .abort(abort),
    .timeout_counts(timeout_counts), .seg_ready(seg_ready), .seg_valid(seg_valid),
    .seg_data(seg_data), .recording(recording), .status(status), .n_segments(n_segments)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  function automatic logic [127:0] mk(input int h, input int l, input int r);
    logic [47:0] hh, ll;
    logic [31:0] rr;
    hh = 48'(h);
    ll = 48'(l);
    rr = 32'(r);
    return {hh, ll, rr};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l);
    sig_in = 1'b1;
    tick(h);
    sig_in = 1'b0;
    tick(l);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (recording === 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, {127'b0, recording}, 128'd0);
  endtask

  // every accepted word must be the oldest outstanding expectation
  always @(negedge refclk) begin
    if (seg_valid === 1'b1 && seg_ready === 1'b1) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word: observed %0h expected no word", seg_data);
      end
      if (exp_q.size() != 0) check("seg_word", seg_data, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; sig_in = 1'b0; arm = 1'b0; abort = 1'b0;
    timeout_counts = '0; seg_ready = 1'b1;
    tick(2);
    check("rst_valid", {127'b0, seg_valid}, 128'd0);
    check("rst_data", seg_data, 128'd0);
    check("rst_rec", {127'b0, recording}, 128'd0);
    check("rst_status", {112'b0, status}, 128'd0);
    check("rst_nseg", {96'b0, n_segments}, 128'd0);
    reset = 1'b0;
    tick(2);

    // square wave 3/5, last low closed by the timeout
    timeout_counts = 48'd20;
    exp_q.push_back(mk(3, 5, 9));
    exp_q.push_back(mk(3, 20, 1));
    do_arm();
    check("t1_rec", {127'b0, recording}, 128'd1);
    repeat (9) pulse(3, 5);
    pulse(3, 0);
    wait_idle("t1_idle", 80);
    tick(3);
    check("t1_status", {112'b0, status}, 128'h1);
    check("t1_nseg", {96'b0, n_segments}, 128'd2);
    check("t1_drained", 128'(exp_q.size()), 128'd0);

    // mixed runs
    timeout_counts = 48'd8;
    exp_q.push_back(mk(2, 2, 4));
    exp_q.push_back(mk(6, 1, 3));
    exp_q.push_back(mk(2, 2, 1));
    exp_q.push_back(mk(2, 8, 1));
    do_arm();
    repeat (4) pulse(2, 2);
    repeat (3) pulse(6, 1);
    pulse(2, 2);
    pulse(2, 0);
    wait_idle("t2_idle", 60);
    tick(3);
    check("t2_status", {112'b0, status}, 128'h1);
    check("t2_nseg", {96'b0, n_segments}, 128'd4);
    check("t2_drained", 128'(exp_q.size()), 128'd0);

    // no ready: first word held, second dropped
    timeout_counts = 48'd0;
    seg_ready = 1'b0;
    do_arm();
    pulse(2, 3);
    pulse(4, 2);
    pulse(3, 3);
    sig_in = 1'b1;
    tick(6);
    check("t3_valid", {127'b0, seg_valid}, 128'd1);
    check("t3_data", seg_data, mk(2, 3, 1));
    check("t3_status", {112'b0, status}, 128'h8);
    check("t3_nseg", {96'b0, n_segments}, 128'd1);
    tick(5);
    check("t3_stable", seg_data, mk(2, 3, 1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_status", {112'b0, status}, 128'hA);
    check("t3_abort_rec", {127'b0, recording}, 128'd0);
    check("t3_held_valid", {127'b0, seg_valid}, 128'd1);
    exp_q.push_back(mk(2, 3, 1));
    seg_ready = 1'b1;
    tick(3);
    check("t3_drain_valid", {127'b0, seg_valid}, 128'd0);
    check("t3_drained", 128'(exp_q.size()), 128'd0);
    sig_in = 1'b0;
    tick(4);

    // stuck high after a (4,4) pair
    timeout_counts = 48'd50;
    exp_q.push_back(mk(4, 4, 1));
    do_arm();
    pulse(4, 4);
    sig_in = 1'b1;
    tick(100);
    sig_in = 1'b0;
    wait_idle("t4_idle", 5);
    tick(3);
    check("t4_status", {112'b0, status}, 128'h4);
    check("t4_nseg", {96'b0, n_segments}, 128'd1);
    check("t4_drained", 128'(exp_q.size()), 128'd0);

    // abort in LOW discards the pending run
    timeout_counts = 48'd0;
    exp_q.push_back(mk(2, 2, 1));
    do_arm();
    pulse(2, 2);
    repeat (5) pulse(3, 3);
    pulse(3, 6);
    check("t5_nseg_pre", {96'b0, n_segments}, 128'd1);
    check("t5_rec_pre", {127'b0, recording}, 128'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_status", {112'b0, status}, 128'h2);
    check("t5_rec", {127'b0, recording}, 128'd0);
    tick(10);
    check("t5_no_word", {127'b0, seg_valid}, 128'd0);
    check("t5_drained", 128'(exp_q.size()), 128'd0);

    // arm with abort in IDLE is ignored
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    tick(3);
    check("t6_rec", {127'b0, recording}, 128'd0);
    check("t6_status", {112'b0, status}, 128'h2);
    check("t6_nseg", {96'b0, n_segments}, 128'd1);

    // re-arm clears counters; reset mid-HIGH with a held word
    seg_ready = 1'b0;
    do_arm();
    check("t7_rec", {127'b0, recording}, 128'd1);
    check("t7_status", {112'b0, status}, 128'h0);
    check("t7_nseg", {96'b0, n_segments}, 128'd0);
    pulse(2, 2);
    pulse(3, 3);
    sig_in = 1'b1;
    tick(6);
    check("t7_held", {127'b0, seg_valid}, 128'd1);
    reset = 1'b1;
    tick();
    check("t7_rst_valid", {127'b0, seg_valid}, 128'd0);
    check("t7_rst_data", seg_data, 128'd0);
    check("t7_rst_rec", {127'b0, recording}, 128'd0);
    check("t7_rst_status", {112'b0, status}, 128'd0);
    check("t7_rst_nseg", {96'b0, n_segments}, 128'd0);
    reset = 1'b0;
    sig_in = 1'b0;
    seg_ready = 1'b1;
    tick(4);
    check("final_queue", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
